// File: rtl/gps_ser_reader_pkg.sv
// Shared definitions for the GPS serial read port: GET_* op bit positions,
// word width and the reader FSM state type.
package gps_ser_reader_pkg;

    localparam int unsigned GET_CHAN_IQ  = 0;
    localparam int unsigned GET_SRQ      = 1;
    localparam int unsigned GET_SNAPSHOT = 2;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_EMIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gps_ser_pack.sv
// 16-bit MSB-first pack register: successive bits fill word[15] down to word[0].
// full flags that the slot being written now is the last one in the word.
module gps_ser_pack
    import gps_ser_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              bit_en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [3:0]        pos_q, pos_d;

    always_comb begin
        word_d = word_q;
        pos_d  = pos_q;
        if (clr) begin
            word_d = '0;
            pos_d  = '0;
        end else if (bit_en) begin
            word_d[4'd15 - pos_q] = bit_in;
            pos_d                 = pos_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            pos_q  <= '0;
        end else begin
            word_q <= word_d;
            pos_q  <= pos_d;
        end
    end

    assign word = word_q;
    assign full = (pos_q == 4'd15);

endmodule

// File: rtl/gps_ser_reader.sv
// Host-side GPS serial read port: one rdReg load strobe, then one rdBit per bit,
// packing ser MSB-first into 16-bit words delivered over valid/ready.
module gps_ser_reader
    import gps_ser_reader_pkg::*;
#(
    parameter int unsigned MAX_BITS = 256,
    parameter int unsigned CNT_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        sel,
    input  logic [CNT_W-1:0]  nbits,
    output logic              busy,
    output logic              done,
    output logic              rdReg,
    output logic              rdBit,
    output logic [15:0]       op,
    input  logic              ser,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    state_e           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] nbits_clamped;
    logic             pk_clr, pk_en, pk_full;

    assign nbits_clamped = (nbits > CNT_W'(MAX_BITS)) ? CNT_W'(MAX_BITS) : nbits;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        remain_d = remain_q;
        pk_clr   = 1'b0;
        pk_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (sel != 3'b000)) begin
                    sel_d    = sel;
                    remain_d = nbits_clamped;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pk_clr  = 1'b1;
                state_d = (remain_q == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                // ser reflects the current shifter MSB; it is captured on the same edge rdBit shifts
                pk_en    = 1'b1;
                remain_d = remain_q - 1'b1;
                if (pk_full || (remain_q == CNT_W'(1)))
                    state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (dout_ready) begin
                    pk_clr  = 1'b1;
                    state_d = (remain_q == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            remain_q <= remain_d;
        end
    end

    gps_ser_pack u_pack (
        .clk    (clk),
        .rst    (rst),
        .clr    (pk_clr),
        .bit_en (pk_en),
        .bit_in (ser),
        .word   (dout),
        .full   (pk_full)
    );

    always_comb begin
        op = '0;
        if (state_q == ST_LOAD) begin
            op[GET_CHAN_IQ]  = sel_q[GET_CHAN_IQ];
            op[GET_SRQ]      = sel_q[GET_SRQ];
            op[GET_SNAPSHOT] = sel_q[GET_SNAPSHOT];
        end
    end

    assign busy       = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_EMIT);
    assign done       = (state_q == ST_DONE);
    assign rdReg      = (state_q == ST_LOAD);
    assign rdBit      = (state_q == ST_SHIFT);
    assign dout_valid = (state_q == ST_EMIT);

endmodule

// File: tb/tb_gps_ser_reader.sv
// Directed bench for gps_ser_reader with a behavioural GPS-side shifter model.
module tb_gps_ser_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  sel = 3'b000;
    logic [8:0]  nbits = '0;
    logic        busy, done, rdReg, rdBit, ser, dout_valid;
    logic        dout_ready = 1'b1;
    logic [15:0] op, dout;

    gps_ser_reader #(.MAX_BITS(256), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .nbits(nbits),
        .busy(busy), .done(done), .rdReg(rdReg), .rdBit(rdBit), .op(op),
        .ser(ser), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    // GPS-side shifter: load on rdReg by op bit, shift on rdBit, ser = MSB
    logic [255:0] sh = '0;
    logic [255:0] pat [3];
    always @(posedge clk) begin
        if (rdReg) begin
            if (op[0])      sh <= pat[0];
            else if (op[1]) sh <= pat[1];
            else if (op[2]) sh <= pat[2];
        end else if (rdBit) begin
            sh <= sh << 1;
        end
    end
    assign ser = sh[255];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] words [$];
    int          rdbit_cnt, rdreg_cnt, overlap_cnt, emit_bit_cnt, done_cyc;
    logic [15:0] op_seen;
    logic        timed_out;

    task automatic run(input logic [2:0] s, input logic [8:0] n, input int stall_word,
                       input int stall_len, input int glitch_cyc, input int stop_bits);
        int cyc;
        int stall_left;
        logic stopped;
        words.delete();
        rdbit_cnt = 0; rdreg_cnt = 0; overlap_cnt = 0; emit_bit_cnt = 0; done_cyc = 0;
        op_seen = '0; timed_out = 1'b0; stopped = 1'b0;
        stall_left = stall_len;
        @(negedge clk);
        sel = s; nbits = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            start = (cyc == glitch_cyc);
            if (rdReg && rdBit) overlap_cnt++;
            if (rdReg) begin rdreg_cnt++; op_seen = op; end
            if (rdBit) rdbit_cnt++;
            if (dout_valid && rdBit) emit_bit_cnt++;
            if (dout_valid) begin
                if (words.size() == stall_word && stall_left > 0) begin
                    dout_ready = 1'b0;
                    stall_left--;
                end else begin
                    dout_ready = 1'b1;
                    words.push_back(dout);
                end
            end else begin
                dout_ready = 1'b1;
            end
            if (done) begin done_cyc = cyc; break; end
            if (stop_bits > 0 && rdbit_cnt == stop_bits) begin stopped = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        dout_ready = 1'b1;
        if (done_cyc == 0 && !stopped) timed_out = 1'b1;
        check("timeout", 64'(timed_out), 64'd0);
    endtask

    initial begin
        pat[0] = '0; pat[1] = '0; pat[2] = '0;
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_outs", {done, rdReg, rdBit, dout_valid}, 0);
        check("rst_op", 64'(op), 0);
        check("rst_dout", 64'(dout), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 1: SRQ 13 bits
        pat[1] = {13'b1_0110_0000_0011, 243'd0};
        run(3'b010, 9'd13, -1, 0, 0, 0);
        check("t1_nwords", words.size(), 1);
        check("t1_word", 64'(words[0]), 64'hB018);
        check("t1_rdbit", rdbit_cnt, 13);
        check("t1_op", 64'(op_seen), 64'h0002);
        check("t1_done_cyc", done_cyc, 16);
        check("t1_overlap", overlap_cnt, 0);

        // 2: snapshot 48 bits, no stall
        pat[2] = {48'h0123_4567_89AB, 208'd0};
        run(3'b100, 9'd48, -1, 0, 0, 0);
        check("t2_nwords", words.size(), 3);
        check("t2_w0", 64'(words[0]), 64'h0123);
        check("t2_w1", 64'(words[1]), 64'h4567);
        check("t2_w2", 64'(words[2]), 64'h89AB);
        check("t2_done_cyc", done_cyc, 53);
        check("t2_rdbit", rdbit_cnt, 48);

        // 3: same with 10-cycle stall on word 1
        run(3'b100, 9'd48, 1, 10, 0, 0);
        check("t3_nwords", words.size(), 3);
        check("t3_w0", 64'(words[0]), 64'h0123);
        check("t3_w1", 64'(words[1]), 64'h4567);
        check("t3_w2", 64'(words[2]), 64'h89AB);
        check("t3_rdbit", rdbit_cnt, 48);
        check("t3_emit_rdbit", emit_bit_cnt, 0);
        check("t3_done_cyc", done_cyc, 63);

        // 4: zero-length chan IQ
        run(3'b001, 9'd0, -1, 0, 0, 0);
        check("t4_rdreg", rdreg_cnt, 1);
        check("t4_op", 64'(op_seen), 64'h0001);
        check("t4_rdbit", rdbit_cnt, 0);
        check("t4_nwords", words.size(), 0);
        check("t4_done_cyc", done_cyc, 2);

        // partial last word: 20 bits
        pat[0] = {20'hABCDE, 236'd0};
        run(3'b001, 9'd20, -1, 0, 0, 0);
        check("p20_nwords", words.size(), 2);
        check("p20_w0", 64'(words[0]), 64'hABCD);
        check("p20_w1", 64'(words[1]), 64'hE000);
        check("p20_done_cyc", done_cyc, 1 + 20 + 2 + 1);

        // nbits above MAX_BITS clamps to 256
        run(3'b100, 9'd300, -1, 0, 0, 0);
        check("clamp_rdbit", rdbit_cnt, 256);
        check("clamp_nwords", words.size(), 16);
        check("clamp_w0", 64'(words[0]), 64'h0123);
        check("clamp_done_cyc", done_cyc, 274);

        // 5: asynchronous reset after 7 rdBit pulses of a 32-bit read
        run(3'b100, 9'd32, -1, 0, 0, 7);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_flags", {busy, done, rdReg, rdBit, dout_valid}, 0);
        check("t5_op", 64'(op), 0);
        check("t5_dout", 64'(dout), 0);
        @(negedge clk);
        rst = 1'b0;
        pat[1] = {16'hC3A5, 240'd0};
        run(3'b010, 9'd16, -1, 0, 0, 0);
        check("t5_nwords", words.size(), 1);
        check("t5_word", 64'(words[0]), 64'hC3A5);

        // 6: start during SHIFT ignored
        pat[1] = {16'h5A0F, 240'd0};
        run(3'b010, 9'd16, -1, 0, 5, 0);
        check("t6_rdreg", rdreg_cnt, 1);
        check("t6_word", 64'(words[0]), 64'h5A0F);
        check("t6_done_cyc", done_cyc, 19);
        // start with sel==0 in IDLE ignored
        @(negedge clk);
        sel = 3'b000; nbits = 9'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rdreg_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (rdReg || busy) rdreg_cnt++;
            @(negedge clk);
        end
        check("t6_sel0_ignored", rdreg_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
